// File: rtl/packet_to_axis.sv
// Transmit-side packet encoder: queues strobed packets in a small FIFO and
// serializes each as a header word (magic + index) followed by its data words.
module packet_to_axis #(
  parameter int DATA_WIDTH      = 32,
  parameter int MAGIC_WIDTH     = 16,
  parameter int MAGIC_START_BIT = 16,
  parameter int INDEX_WIDTH     = 5,
  parameter int INDEX_START_BIT = 10,
  parameter int NUM_DATA_WORDS  = 1,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                 auroraClk,
  input  logic                                 arstn,
  input  logic [MAGIC_WIDTH-1:0]               headerMagic,
  input  logic                                 packetStrobe,
  input  logic [INDEX_WIDTH-1:0]               packetIndex,
  input  logic [DATA_WIDTH*NUM_DATA_WORDS-1:0] packetData,
  output logic                                 fifoFull,
  output logic                                 overflowStrobe,
  output logic [15:0]                          overflowCount,
  output logic                                 busy,
  output logic                                 TVALID,
  output logic                                 TLAST,
  output logic [DATA_WIDTH-1:0]                TDATA,
  input  logic                                 TREADY
);

  localparam int PAY_W = DATA_WIDTH * NUM_DATA_WORDS;
  localparam int ENT_W = INDEX_WIDTH + PAY_W;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int WC_W  = (NUM_DATA_WORDS > 1) ? $clog2(NUM_DATA_WORDS) : 1;

  if (INDEX_START_BIT + INDEX_WIDTH > MAGIC_START_BIT) begin : g_bad_index
    $error("packet_to_axis: index field overlaps magic field");
  end
  if (MAGIC_START_BIT + MAGIC_WIDTH > DATA_WIDTH) begin : g_bad_magic
    $error("packet_to_axis: magic field exceeds DATA_WIDTH");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("packet_to_axis: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (NUM_DATA_WORDS < 1) begin : g_bad_words
    $error("packet_to_axis: NUM_DATA_WORDS must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

  function automatic logic [DATA_WIDTH-1:0] make_header(
    input logic [MAGIC_WIDTH-1:0] magic,
    input logic [INDEX_WIDTH-1:0] idx
  );
    logic [DATA_WIDTH-1:0] h;
    h = '0;
    h[MAGIC_START_BIT +: MAGIC_WIDTH] = magic;
    h[INDEX_START_BIT +: INDEX_WIDTH] = idx;
    return h;
  endfunction

  // Word n of the payload, most-significant word first.
  function automatic logic [DATA_WIDTH-1:0] data_word(
    input logic [PAY_W-1:0] p,
    input logic [WC_W-1:0]  n
  );
    logic [PAY_W-1:0] s;
    s = p >> (DATA_WIDTH * (NUM_DATA_WORDS - 1 - int'(n)));
    return s[DATA_WIDTH-1:0];
  endfunction

  logic [ENT_W-1:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, full_d;
  logic                  ovf_strobe_q, ovf_strobe_d;
  logic [15:0]           ovf_count_q, ovf_count_d;
  state_t                state_q, state_d;
  logic [PAY_W-1:0]      payload_q, payload_d;
  logic [WC_W-1:0]       wcnt_q, wcnt_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;

  logic                  push, pop, drop, fifo_empty, xfer;
  logic [ENT_W-1:0]      head;
  logic [DATA_WIDTH-1:0] head_hdr;

  assign push       = packetStrobe && !full_q;
  assign drop       = packetStrobe && full_q;
  assign fifo_empty = (count_q == '0);
  assign xfer       = tvalid_q && TREADY;
  assign head       = mem_q[rd_ptr_q];
  assign head_hdr   = make_header(headerMagic, head[ENT_W-1 -: INDEX_WIDTH]);

  always_comb begin
    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    full_d      = (count_d == CNT_W'(FIFO_DEPTH));
    ovf_strobe_d = drop;
    ovf_count_d  = ovf_count_q;
    if (drop && (ovf_count_q != 16'hFFFF)) begin
      ovf_count_d = ovf_count_q + 16'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    payload_d = payload_q;
    wcnt_d    = wcnt_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          payload_d = head[PAY_W-1:0];
          tdata_d   = head_hdr;
          tvalid_d  = 1'b1;
          tlast_d   = 1'b0;
          state_d   = HEADER;
        end
      end
      HEADER: begin
        if (xfer) begin
          tdata_d = data_word(payload_q, '0);
          tlast_d = (NUM_DATA_WORDS == 1);
          wcnt_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          if (!tlast_q) begin
            wcnt_d  = wcnt_q + WC_W'(1);
            tdata_d = data_word(payload_q, wcnt_d);
            tlast_d = (int'(wcnt_d) == NUM_DATA_WORDS - 1);
          end else if (!fifo_empty) begin
            // Chain straight into the next header so back-to-back packets have no gap.
            pop       = 1'b1;
            payload_d = head[PAY_W-1:0];
            tdata_d   = head_hdr;
            tlast_d   = 1'b0;
            state_d   = HEADER;
          end else begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge auroraClk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {packetIndex, packetData};
    end
  end

  always_ff @(posedge auroraClk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      ovf_strobe_q <= 1'b0;
      ovf_count_q  <= '0;
      state_q      <= IDLE;
      payload_q    <= '0;
      wcnt_q       <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      ovf_strobe_q <= ovf_strobe_d;
      ovf_count_q  <= ovf_count_d;
      state_q      <= state_d;
      payload_q    <= payload_d;
      wcnt_q       <= wcnt_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
    end
  end

  assign fifoFull       = full_q;
  assign overflowStrobe = ovf_strobe_q;
  assign overflowCount  = ovf_count_q;
  assign busy           = (state_q != IDLE) || !fifo_empty;
  assign TVALID         = tvalid_q;
  assign TLAST          = tlast_q;
  assign TDATA          = tdata_q;

endmodule

// File: tb/tb_packet_to_axis.sv
// Bench for packet_to_axis: one-word and three-word instances share stimulus and
// are compared every cycle against a packet-level occupancy/beat model.
module tb_packet_to_axis;

  logic        auroraClk = 1'b0;
  logic        arstn;
  logic [15:0] headerMagic;
  logic        packetStrobe;
  logic [4:0]  packetIndex;
  logic [95:0] pd;
  logic        TREADY;

  logic        tv [2];
  logic        tl [2];
  logic        ff [2];
  logic        os [2];
  logic        bz [2];
  logic [31:0] td [2];
  logic [15:0] oc [2];

  always #5 auroraClk = ~auroraClk;

  packet_to_axis #(.NUM_DATA_WORDS(1)) u1 (
    .auroraClk(auroraClk), .arstn(arstn), .headerMagic(headerMagic),
    .packetStrobe(packetStrobe), .packetIndex(packetIndex), .packetData(pd[31:0]),
    .fifoFull(ff[0]), .overflowStrobe(os[0]), .overflowCount(oc[0]), .busy(bz[0]),
    .TVALID(tv[0]), .TLAST(tl[0]), .TDATA(td[0]), .TREADY(TREADY)
  );

  packet_to_axis #(.NUM_DATA_WORDS(3)) u3 (
    .auroraClk(auroraClk), .arstn(arstn), .headerMagic(headerMagic),
    .packetStrobe(packetStrobe), .packetIndex(packetIndex), .packetData(pd),
    .fifoFull(ff[1]), .overflowStrobe(os[1]), .overflowCount(oc[1]), .busy(bz[1]),
    .TVALID(tv[1]), .TLAST(tl[1]), .TDATA(td[1]), .TREADY(TREADY)
  );

  int checks = 0;
  int errors = 0;
  int pkts0  = 0;

  // Reference model state, per instance: queued packets, packet on the wire, beats left.
  int          wr [2];
  int          rd [2];
  int          left [2];
  bit          infl [2];
  bit          mfull [2];
  bit          movf [2];
  logic [15:0] mcnt [2];
  logic [4:0]  ridx [2][16];
  logic [95:0] rdat [2][16];
  logic [4:0]  cidx [2];
  logic [95:0] cdat [2];
  logic [15:0] cmag [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nwords(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      wr[k] = 0; rd[k] = 0; left[k] = 0; infl[k] = 0;
      mfull[k] = 0; movf[k] = 0; mcnt[k] = 16'd0;
    end
  endtask

  task automatic model_start(input int k);
    cidx[k] = ridx[k][rd[k][3:0]];
    cdat[k] = rdat[k][rd[k][3:0]];
    cmag[k] = headerMagic;
    rd[k]++;
    infl[k] = 1;
    left[k] = 1 + nwords(k);
  endtask

  task automatic model_edge(input int k);
    int pend;
    bit accept;
    pend   = wr[k] - rd[k];
    accept = packetStrobe && !mfull[k];
    movf[k] = packetStrobe && mfull[k];
    if (movf[k] && mcnt[k] != 16'hFFFF) mcnt[k] = mcnt[k] + 16'd1;
    if (infl[k]) begin
      if (TREADY) begin
        left[k]--;
        if (left[k] == 0) begin
          if (pend > 0) model_start(k);
          else infl[k] = 0;
        end
      end
    end else if (pend > 0) begin
      model_start(k);
    end
    if (accept) begin
      ridx[k][wr[k][3:0]] = packetIndex;
      rdat[k][wr[k][3:0]] = pd;
      wr[k]++;
    end
    mfull[k] = ((wr[k] - rd[k]) == 4);
  endtask

  function automatic logic [31:0] exp_word(input int k);
    int w;
    logic [95:0] t;
    w = (1 + nwords(k)) - left[k];
    if (w == 0) return (32'(cmag[k]) << 16) | (32'(cidx[k]) << 10);
    t = cdat[k] >> (32 * (nwords(k) - w));
    return t[31:0];
  endfunction

  task automatic check(input int k);
    string s;
    s = (k == 0) ? "n1" : "n3";
    chk({s, "_tvalid"}, 32'(tv[k]), 32'(infl[k]));
    chk({s, "_tlast"}, 32'(tl[k]), 32'(infl[k] && left[k] == 1));
    if (infl[k]) chk({s, "_tdata"}, td[k], exp_word(k));
    chk({s, "_fifoFull"}, 32'(ff[k]), 32'(mfull[k]));
    chk({s, "_busy"}, 32'(bz[k]), 32'(infl[k] || (wr[k] - rd[k]) > 0));
    chk({s, "_ovfStrobe"}, 32'(os[k]), 32'(movf[k]));
    chk({s, "_ovfCount"}, 32'(oc[k]), 32'(mcnt[k]));
  endtask

  task automatic step();
    if (tv[0] && TREADY && tl[0]) pkts0++;
    @(posedge auroraClk);
    if (arstn) for (int k = 0; k < 2; k++) model_edge(k);
    @(negedge auroraClk);
    for (int k = 0; k < 2; k++) check(k);
    packetStrobe = 1'b0;
  endtask

  function automatic bit model_busy();
    return infl[0] || infl[1] || (wr[0] != rd[0]) || (wr[1] != rd[1]);
  endfunction

  task automatic strobe(input logic [4:0] idx, input logic [95:0] data);
    packetIndex  = idx;
    pd           = data;
    packetStrobe = 1'b1;
  endtask

  initial begin
    arstn = 1'b0; packetStrobe = 1'b0; packetIndex = '0; pd = '0;
    headerMagic = 16'hB6CF; TREADY = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      check(k);
      chk($sformatf("rst_tdata%0d", k), td[k], 32'h0);
    end
    step(); step();
    arstn = 1'b1;

    // Single packet with the reference header/data values
    TREADY = 1'b1;
    strobe(5'd3, {32'h11111111, 32'h22222222, 32'h03CACA01});
    step();
    chk("sp_idle_gap", 32'(tv[0]), 32'h0);
    step();
    chk("sp_hdr_valid", 32'(tv[0]), 32'h1);
    chk("sp_hdr_data", td[0], 32'hB6CF0C00);
    chk("sp_hdr_last", 32'(tl[0]), 32'h0);
    chk("sp3_hdr_data", td[1], 32'hB6CF0C00);
    step();
    chk("sp_dat_data", td[0], 32'h03CACA01);
    chk("sp_dat_last", 32'(tl[0]), 32'h1);
    chk("sp3_w0_data", td[1], 32'h11111111);
    step();
    chk("sp_end_valid", 32'(tv[0]), 32'h0);
    chk("sp3_w1_data", td[1], 32'h22222222);
    repeat (4) step();

    // Burst of four spaced strobes
    for (int i = 0; i < 4; i++) begin
      strobe(5'(i), {$urandom, $urandom, $urandom});
      repeat (8) step();
    end
    chk("burst_no_ovf", 32'(oc[0]), 32'h0);

    // Backpressure with random ready and changing magic
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 3; j++) begin
        TREADY = 1'($urandom_range(0, 1));
        headerMagic = 16'($urandom);
        if (j == 0) strobe(5'($urandom), {$urandom, $urandom, $urandom});
        step();
      end
    end
    for (int i = 0; i < 400 && model_busy(); i++) begin
      TREADY = 1'($urandom_range(0, 1));
      step();
    end
    headerMagic = 16'hB6CF;
    TREADY = 1'b1;
    for (int i = 0; i < 20 && model_busy(); i++) step();
    chk("bp_drained", 32'(bz[0] || bz[1]), 32'h0);

    // Overflow under full stall, then a drop on a popping edge
    TREADY = 1'b0;
    for (int i = 0; i < 6; i++) begin
      strobe(5'(i + 8), {$urandom, $urandom, $urandom});
      step();
    end
    chk("ovf_full", 32'(ff[0]), 32'h1);
    chk("ovf_pulse", 32'(os[0]), 32'h1);
    chk("ovf_count1", 32'(oc[0]) - 32'(mcnt[0]) + 32'h1, 32'h1);
    step();
    chk("ovf_pulse_once", 32'(os[0]), 32'h0);
    pkts0 = 0;
    TREADY = 1'b1;
    step();
    strobe(5'd30, {$urandom, $urandom, $urandom});
    step();
    chk("ovf_pop_drop", 32'(ff[0]), 32'h0);
    for (int i = 0; i < 100 && model_busy(); i++) step();
    step();
    chk("ovf_emitted", 32'(pkts0), 32'd5);

    // Reset while a header is stalled with two packets queued
    TREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      strobe(5'(i + 16), {$urandom, $urandom, $urandom});
      step();
    end
    step();
    chk("mid_valid_before", 32'(tv[0]), 32'h1);
    #2 arstn = 1'b0;
    #1;
    model_reset();
    chk("mid_valid_drop", 32'(tv[0]), 32'h0);
    chk("mid_ovf_clear", 32'(oc[0]), 32'h0);
    for (int k = 0; k < 2; k++) check(k);
    @(negedge auroraClk);
    step();
    arstn = 1'b1;
    pkts0 = 0;
    TREADY = 1'b1;
    strobe(5'd21, {$urandom, $urandom, $urandom});
    step();
    for (int i = 0; i < 12; i++) step();
    chk("mid_only_new", 32'(pkts0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/packet_to_axis.md
Name: packet_to_axis

Overview:
- Transmit-side packet encoder, the counterpart of the existing AXIS2Packet checker.
- Accepts single-cycle packet strobes carrying an index and NUM_DATA_WORDS data words, and queues them in a small FIFO.
- Serializes each packet onto an AXI-Stream master as one header word (magic + index) followed by the data words, with TLAST on the final word.
- Used as the FMPS/cell-controller packet source feeding axisMux inputs and Aurora TX links.

Parameters:
- DATA_WIDTH, 32, AXIS word width.
- MAGIC_WIDTH, 16, header magic field width.
- MAGIC_START_BIT, 16, LSB position of magic in the header word.
- INDEX_WIDTH, 5, packet index field width.
- INDEX_START_BIT, 10, LSB position of index in the header word.
- NUM_DATA_WORDS, 1, data words per packet (>=1).
- FIFO_DEPTH, 4, pending-packet queue depth (power of 2, >=2).

Ports:
- auroraClk  in  1  sole clock.
- arstn  in  1  asynchronous, active-low reset.
- headerMagic  in  MAGIC_WIDTH  magic inserted into each header; sampled at header load.
- packetStrobe  in  1  single-cycle request to send one packet.
- packetIndex  in  INDEX_WIDTH  index for the strobed packet.
- packetData  in  DATA_WIDTH*NUM_DATA_WORDS  payload for the strobed packet.
- fifoFull  out  1  queue full; a strobe now is dropped.
- overflowStrobe  out  1  one-cycle pulse per dropped packet.
- overflowCount  out  16  saturating count of dropped packets.
- busy  out  1  high while the FSM is not IDLE or the FIFO is non-empty.
- TVALID  out  1  AXIS valid.
- TLAST  out  1  AXIS last.
- TDATA  out  DATA_WIDTH  AXIS data.
- TREADY  in  1  AXIS ready.

Behaviour:
- Elaboration error if INDEX_START_BIT+INDEX_WIDTH > MAGIC_START_BIT, if MAGIC_START_BIT+MAGIC_WIDTH > DATA_WIDTH, or if FIFO_DEPTH is not a power of 2.
- Reset (arstn low, asynchronous):
  - TVALID, TLAST, TDATA, overflowStrobe, overflowCount are 0; busy is 0.
  - FIFO emptied; fifoFull is 0; FSM in IDLE.
  - Reset mid-packet drops TVALID immediately and discards the partial packet and all queued packets.
  - Release is synchronous to auroraClk; the first strobe is accepted on the first edge with arstn high.
- FIFO:
  - Each entry stores {packetIndex, packetData}.
  - Push on packetStrobe && !fifoFull.
  - fifoFull is registered and equals (count == FIFO_DEPTH).
  - A strobe while fifoFull=1 is dropped even if a pop occurs on the same edge. It pulses overflowStrobe the next cycle and increments overflowCount, which saturates at 16'hFFFF.
  - Simultaneous push and pop when not full leaves count unchanged.
- Header word:
  - headerMagic at [MAGIC_START_BIT +: MAGIC_WIDTH].
  - Index at [INDEX_START_BIT +: INDEX_WIDTH].
  - All other bits 0.
- Data word order: word 0 = packetData[DATA_WIDTH*NUM_DATA_WORDS-1 -: DATA_WIDTH] (most-significant word first), then descending.
- FSM states:
  - IDLE: TVALID=0. If FIFO non-empty: pop the head, register the header into TDATA, set TVALID=1, TLAST=0, go to HEADER.
  - HEADER: hold TDATA/TVALID until TVALID&TREADY. On transfer, load data word 0, set TLAST = (NUM_DATA_WORDS==1), go to DATA with word counter 0.
  - DATA: hold until transfer. On transfer of a non-last word, increment the counter, load the next word, and set TLAST when counter == NUM_DATA_WORDS-1. On transfer of the last word:
    - if the FIFO is non-empty, pop and load the next header the same edge (no bubble) and go to HEADER;
    - otherwise set TVALID=0, TLAST=0 and go to IDLE.
- Latency: strobe sampled at edge E0 into an empty, idle block gives TVALID high after edge E1 (one idle cycle).
- AXIS rules:
  - TDATA and TLAST are stable while TVALID && !TREADY.
  - TVALID never deasserts without a transfer, except on reset.
  - TREADY is ignored when TVALID=0.
- Throughput: with TREADY held high, a packet occupies exactly 1+NUM_DATA_WORDS cycles, and back-to-back packets have no gaps.

Test Plan:
- Single packet: reset, magic=16'hB6CF, strobe index=3, data=32'h03CACA01, TREADY=1 → TVALID rises after E1; beats 32'hB6CF0C00 (TLAST=0) then 32'h03CACA01 (TLAST=1); TVALID=0 next cycle.
- Burst of 4 strobes, one every 8 cycles, indices 0..3 → 8 beats, each header carries the correct index, no overflow, AXIS2Packet reports no errors.
- Backpressure: TREADY random at 50% with 16 packets spaced at 3 cycles, FIFO_DEPTH=4 → payload order preserved, TDATA stable during stalls, no beat lost or duplicated.
- Overflow: TREADY=0, strobe 6 times → fifoFull=1 after the 4th push (5th including the packet in the output register per the FSM), overflowCount=1, one overflowStrobe pulse. Then TREADY=1 → exactly 5 packets emitted. Also strobe on a full-and-popping edge → dropped and counted.
- NUM_DATA_WORDS=3 variant → 4 beats per packet, TLAST only on the 4th, MS data word first.
- Reset mid-packet: assert arstn=0 while HEADER is stalled with 2 packets queued → TVALID=0 immediately, overflowCount=0. After release, a new strobe is sent cleanly and no stale packets appear.
